loop_rply_buf: RTL
==================

Name: loop_rply_buf

Overview:
- Consumer end of the loop-address-table (LAT) dispatch interface.
- While LAT dispatches a loop, the block captures the loop body from the fetch bundle, using the LAT per-lane valid mask and loop-start strobe.
- When LAT stalls fetch, the block replays the captured body 4-wide to decode, iteration after iteration, until LAT signals unroll finished or a mispredict flushes it.
- Sits between IF/LAT and the decode stage.

Parameters:
- DEPTH, 64, body entries stored (max loop length in instructions; power of two).
- IW, 16, instruction and PC lane width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_in  in  64  fetch bundle; lane0=[63:48] … lane3=[15:0].
- pc_in  in  64  PCs for the bundle, same lane order.
- inst_valid_in  in  4  LAT lane-valid mask; contiguous prefix only (1000/1100/1110/1111).
- loop_strt_in  in  1  LAT loop-start hit for the current bundle.
- stll_ftch_in  in  1  LAT fetch stall; starts replay.
- fnsh_unrll_in  in  1  LAT unroll finished; the current iteration is the last one.
- mis_pred_in  in  1  flush.
- dec_rdy_in  in  1  decode accepts the replay bundle this cycle.
- rply_inst_out  out  64  replayed instructions, lane order as inst_in.
- rply_pc_out  out  64  replayed PCs.
- rply_vld_out  out  4  replay lane valids, contiguous prefix.
- rply_actv_out  out  1  high in REPLAY; decode muxes replay over fetch.
- lb_state_out  out  2  current state encoding.
- ovf_out  out  1  sticky: the last capture exceeded DEPTH; cleared on the next loop_strt_in.
- iter_cnt_out  out  7  completed replay iterations, saturating at 127.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; wr_ptr, rd_ptr, len, iter_cnt=0; fin_lat=0.
  - All outputs 0.
- States: IDLE=00, CAPT=01, RPLY=10, DRAIN=11.
- Entry storage: {pc,inst}, 32 bits, no reset on the array.
- Lane count: cnt = number of ones in inst_valid_in (0..4).
- IDLE:
  - On loop_strt_in: write the bundle's cnt lanes at entries 0..cnt-1, set wr_ptr=cnt, clear ovf_out, go to CAPT.
  - A bundle with loop_strt_in and inst_valid_in≠1111 is a complete short loop: set len=cnt, go to RPLY on the next stll_ftch_in; otherwise stay in CAPT.
- CAPT, each cycle:
  - Write cnt lanes at wr_ptr..wr_ptr+cnt-1 and advance wr_ptr by cnt.
  - inst_valid_in≠1111 marks loop end: len=final wr_ptr, capture complete.
  - stll_ftch_in with capture complete → RPLY, rd_ptr=0, iter_cnt=0.
  - stll_ftch_in with capture incomplete → IDLE. This is a protocol error; no replay.
  - wr_ptr+cnt>DEPTH → ovf_out=1, discard, go to IDLE.
- RPLY:
  - rply_actv_out=1. The bundle is presented combinationally from rd_ptr; lane k = entry (rd_ptr+k) mod len.
  - Outputs hold stable until dec_rdy_in=1; advance only on dec_rdy_in.
  - On acceptance, rd_ptr ← (rd_ptr+4) mod len.
  - Each wrap past len-1 increments iter_cnt. With len<4 one bundle can wrap several times; iter_cnt adds the number of wraps.
  - fnsh_unrll_in sets fin_lat (sticky until IDLE).
  - When fin_lat=1, lanes after the first wrap are invalid. Valid mask = prefix of length min(4, len-rd_ptr).
  - Acceptance of the bundle that reaches the wrap with fin_lat=1 → DRAIN.
- DRAIN:
  - One cycle, rply_vld_out=0, rply_actv_out=0, then IDLE. len is kept so loop_strt_in can re-capture.
- Mis-prediction:
  - mis_pred_in has highest priority in every state.
  - Next state is IDLE, and rply_vld_out=0 in the same cycle (combinational mask).
  - Pointers and fin_lat clear at the clock edge; iter_cnt holds for debug.
- Simultaneity rules:
  - fnsh_unrll_in in the same cycle as a wrap-producing acceptance counts as fin_lat=1 for that bundle.
  - loop_strt_in is ignored outside IDLE.
- Arithmetic:
  - Pointers are log2(DEPTH)+1 bits.
  - Mod len is implemented by compare-and-subtract (len≤DEPTH, step≤4), never a divider.

Decomposition:
- Shared package lb_pkg holds:
  - state encodings IDLE/CAPT/RPLY/DRAIN (shared with the LAT lbd_state encoding);
  - the lane-slice constants;
  - a function valid-mask→count.
- One natural sub-module: lb_rd_lane_gen, the combinational generator of 4 lane indices plus wrap count and valid prefix from (rd_ptr, len, fin_lat).

Test Plan:
1. Reset mid-RPLY (rst_n low for 1 cycle) → all outputs 0 immediately; lb_state_out=00.
2. Loop of 6 at PC 0x0010..0x0015: loop_strt with 1111, then 1100, then stll_ftch → bundles {0x10–0x13}, {0x14,0x15,0x10,0x11}, {0x12–0x15}; iter_cnt increments 0→1→2.
3. Same loop with fnsh_unrll asserted during bundle 2 → bundle 2 vld=1100; next cycle DRAIN (vld=0000); then IDLE.
4. dec_rdy_in low for 3 cycles mid-replay → outputs stable; rd_ptr unchanged; resumes correctly.
5. Capture of 68 instructions (17 × 1111) → ovf_out=1 at the 17th bundle; state IDLE; no replay on stll_ftch.
6. mis_pred_in during RPLY with dec_rdy_in=1 → rply_vld_out=0000 that cycle; IDLE next cycle; a subsequent loop_strt re-captures cleanly and ovf_out stays 0.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared definitions for the loop replay buffer: state encodings (common with
// the LAT lbd_state field), lane slicing and lane-count helpers.
package lb_pkg;

  localparam logic [1:0] LB_IDLE  = 2'b00;
  localparam logic [1:0] LB_CAPT  = 2'b01;
  localparam logic [1:0] LB_RPLY  = 2'b10;
  localparam logic [1:0] LB_DRAIN = 2'b11;

  localparam int LB_LANES = 4;

  // Lane 0 sits in the most significant slice of a bundle.
  function automatic int lane_lsb(input int lane, input int iw);
    return (LB_LANES - 1 - lane) * iw;
  endfunction

  function automatic logic [2:0] vld_cnt(input logic [3:0] mask);
    return {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};
  endfunction

endpackage

// File: rtl/lb_rd_lane_gen.sv
// Replay read-side lane generator: four modulo-len entry indices from rd_ptr,
// the number of body wraps the bundle covers, the valid prefix and the next rd_ptr.
module lb_rd_lane_gen
  import lb_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic [AW:0]          rd_ptr,
  input  logic [AW:0]          len,
  input  logic                 fin_lat,
  output logic [4*AW-1:0]      lane_idx,
  output logic [2:0]           wraps,
  output logic [3:0]           vld,
  output logic [AW:0]          nxt_ptr
);

  localparam int PW = AW + 1;

  logic [PW-1:0] p;
  logic [PW-1:0] rem;

  // Step one entry per lane; stepping off len-1 returns to 0 and counts a wrap,
  // so no divider is needed even when len is shorter than a bundle.
  always_comb begin
    p        = rd_ptr;
    wraps    = '0;
    lane_idx = '0;
    for (int k = 0; k < LB_LANES; k++) begin
      lane_idx[k*AW +: AW] = p[AW-1:0];
      if (p + 1'b1 == len) begin
        p     = '0;
        wraps = wraps + 3'd1;
      end else begin
        p = p + 1'b1;
      end
    end
    nxt_ptr = p;
    rem     = len - rd_ptr;
    vld     = 4'b1111;
    if (fin_lat && rem < PW'(4))
      vld = 4'b1111 << (3'd4 - rem[2:0]);
  end

endmodule

// File: rtl/loop_rply_buf.sv
// Loop replay buffer: captures a loop body from fetch while LAT dispatches it,
// then replays it 4-wide to decode until unroll finishes or a flush arrives.
module loop_rply_buf
  import lb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4*IW-1:0] inst_in,
  input  logic [4*IW-1:0] pc_in,
  input  logic [3:0]      inst_valid_in,
  input  logic            loop_strt_in,
  input  logic            stll_ftch_in,
  input  logic            fnsh_unrll_in,
  input  logic            mis_pred_in,
  input  logic            dec_rdy_in,
  output logic [4*IW-1:0] rply_inst_out,
  output logic [4*IW-1:0] rply_pc_out,
  output logic [3:0]      rply_vld_out,
  output logic            rply_actv_out,
  output logic [1:0]      lb_state_out,
  output logic            ovf_out,
  output logic [6:0]      iter_cnt_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [1:0]      state;
  logic [PW-1:0]   wr_ptr, rd_ptr, len;
  logic [6:0]      iter_cnt;
  logic            fin_lat, capt_done, ovf;
  logic [2*IW-1:0] mem [DEPTH];

  logic [2:0]      cnt;
  logic [PW-1:0]   wr_base, len_eff, nxt_ptr;
  logic [PW:0]     wr_sum;
  logic            full_mask, ovf_hit, cap_en, end_now, fin_eff, last_bndl;
  logic [4*AW-1:0] wr_addr, lane_idx;
  logic [2:0]      wraps, iter_add;
  logic [3:0]      lane_vld;
  logic [7:0]      iter_sum;
  logic [6:0]      iter_nxt;
  logic [2*IW-1:0] rd_ent [LB_LANES];

  assign cnt       = vld_cnt(inst_valid_in);
  assign full_mask = (inst_valid_in == 4'b1111);
  assign wr_base   = (state == LB_IDLE) ? '0 : wr_ptr;
  assign wr_sum    = {1'b0, wr_base} + {{(PW-2){1'b0}}, cnt};
  assign ovf_hit   = (state == LB_CAPT) && !capt_done && (wr_sum > (PW+1)'(DEPTH));
  assign end_now   = (state == LB_CAPT) && !capt_done && !full_mask;
  assign len_eff   = capt_done ? len : wr_sum[PW-1:0];
  assign cap_en    = !mis_pred_in &&
                     ((state == LB_IDLE && loop_strt_in) ||
                      (state == LB_CAPT && !capt_done && !ovf_hit));

  assign fin_eff   = fin_lat | fnsh_unrll_in;
  assign last_bndl = fin_eff && (wraps != 3'd0);
  // On the final iteration only the first wrap is a real completed iteration.
  assign iter_add  = fin_eff ? {2'b00, wraps != 3'd0} : wraps;
  assign iter_sum  = {1'b0, iter_cnt} + {5'b00000, iter_add};
  assign iter_nxt  = (iter_sum > 8'd127) ? 7'd127 : iter_sum[6:0];

  lb_rd_lane_gen #(.AW(AW)) u_lane_gen (
    .rd_ptr   (rd_ptr),
    .len      (len),
    .fin_lat  (fin_eff),
    .lane_idx (lane_idx),
    .wraps    (wraps),
    .vld      (lane_vld),
    .nxt_ptr  (nxt_ptr)
  );

  always_comb begin
    for (int k = 0; k < LB_LANES; k++)
      wr_addr[k*AW +: AW] = AW'(wr_base + PW'(k));
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LB_LANES; k++) begin
      if (cap_en && 3'(k) < cnt)
        mem[wr_addr[k*AW +: AW]] <= {pc_in[lane_lsb(k, IW) +: IW], inst_in[lane_lsb(k, IW) +: IW]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LB_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len       <= '0;
      iter_cnt  <= '0;
      fin_lat   <= 1'b0;
      capt_done <= 1'b0;
      ovf       <= 1'b0;
    end else if (mis_pred_in) begin
      state     <= LB_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fin_lat   <= 1'b0;
      capt_done <= 1'b0;
    end else begin
      case (state)
        LB_IDLE: begin
          if (loop_strt_in) begin
            state     <= LB_CAPT;
            wr_ptr    <= wr_sum[PW-1:0];
            ovf       <= 1'b0;
            fin_lat   <= 1'b0;
            capt_done <= !full_mask;
            if (!full_mask)
              len <= wr_sum[PW-1:0];
          end
        end
        LB_CAPT: begin
          if (ovf_hit) begin
            ovf       <= 1'b1;
            state     <= LB_IDLE;
            wr_ptr    <= '0;
            capt_done <= 1'b0;
          end else begin
            if (!capt_done)
              wr_ptr <= wr_sum[PW-1:0];
            if (end_now) begin
              len       <= wr_sum[PW-1:0];
              capt_done <= 1'b1;
            end
            // A stall before the loop end was seen is a LAT protocol error: drop the capture.
            if (stll_ftch_in) begin
              if ((capt_done || end_now) && len_eff != '0) begin
                state    <= LB_RPLY;
                rd_ptr   <= '0;
                iter_cnt <= '0;
                fin_lat  <= 1'b0;
              end else begin
                state     <= LB_IDLE;
                wr_ptr    <= '0;
                capt_done <= 1'b0;
              end
            end
          end
        end
        LB_RPLY: begin
          if (fnsh_unrll_in)
            fin_lat <= 1'b1;
          if (dec_rdy_in) begin
            iter_cnt <= iter_nxt;
            if (last_bndl) begin
              state  <= LB_DRAIN;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= nxt_ptr;
            end
          end
        end
        default: begin
          state     <= LB_IDLE;
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          fin_lat   <= 1'b0;
          capt_done <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rply_inst_out = '0;
    rply_pc_out   = '0;
    for (int k = 0; k < LB_LANES; k++) begin
      rd_ent[k] = mem[lane_idx[k*AW +: AW]];
      if (state == LB_RPLY) begin
        rply_inst_out[lane_lsb(k, IW) +: IW] = rd_ent[k][IW-1:0];
        rply_pc_out[lane_lsb(k, IW) +: IW]   = rd_ent[k][2*IW-1:IW];
      end
    end
  end

  assign rply_vld_out  = (state == LB_RPLY && !mis_pred_in) ? lane_vld : 4'b0000;
  assign rply_actv_out = (state == LB_RPLY);
  assign lb_state_out  = state;
  assign ovf_out       = ovf;
  assign iter_cnt_out  = iter_cnt;

endmodule
